bbox_extract: RTL and testbench

BBOX_EXTRACT -- requirements
Module: bbox_extract

---
 rtl/bbox_extract.sv | 215 +++++++++++++++++++++
 tb/tb_bbox_extract.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_extract.sv
`default_nettype none
// ============================================================================
//  Module   : bbox_extract
//  Purpose  : Reads raster-order pixels from a first-word-fall-through FIFO
//             and tracks the bounding box of all non-zero pixels in a frame.
//             When the frame ends, the box is committed to registered outputs
//             if enough hit pixels were seen. Otherwise the previous box is
//             held and box_valid is cleared.
//  Ports    : clock      - rising-edge clock
//             reset      - asynchronous active-high reset
//             in_empty   - upstream FIFO empty flag
//             in_rd_en   - upstream FIFO read strobe (pixel accepted)
//             in_dout    - 24-bit FWFT pixel word
//             x, y       - top-left corner of last committed box
//             width,
//             height     - size of last committed box in pixels
//             box_valid  - last committed frame reached MIN_HITS
//             frame_done - one-cycle pulse as each commit becomes visible
//  Revision : 1.0  initial release
// ============================================================================
module bbox_extract #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MIN_HITS   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_empty,
  output logic        in_rd_en,
  input  logic [23:0] in_dout,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [9:0]  width,
  output logic [9:0]  height,
  output logic        box_valid,
  output logic        frame_done
);

  localparam logic [0:0]  ST_SCAN    = 1'b0;
  localparam logic [0:0]  ST_COMMIT  = 1'b1;

  localparam logic [9:0]  C_LAST_COL = 10'(IMG_WIDTH - 1);
  localparam logic [9:0]  C_LAST_ROW = 10'(IMG_HEIGHT - 1);
  localparam logic [9:0]  C_MIN_INIT = 10'h3FF;
  localparam logic [9:0]  C_MAX_INIT = 10'h000;
  localparam logic [18:0] C_MIN_HITS = 19'(MIN_HITS);
  localparam logic [18:0] C_HIT_SAT  = 19'h7FFFF;

  logic [0:0]  r_state;
  logic [0:0]  w_next_state;

  logic [9:0]  r_col;
  logic [9:0]  r_row;
  logic [9:0]  r_min_x;
  logic [9:0]  r_max_x;
  logic [9:0]  r_min_y;
  logic [9:0]  r_max_y;
  logic [18:0] r_hit_count;

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [9:0]  r_width;
  logic [9:0]  r_height;
  logic        r_box_valid;
  logic        r_frame_done;

  logic        w_rd_en;
  logic        w_commit;
  logic        w_hit;
  logic        w_col_last;
  logic        w_row_last;
  logic        w_last_accept;
  logic        w_box_ok;
  logic [9:0]  w_box_w;
  logic [9:0]  w_box_h;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_SCAN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_SCAN: begin
        if (w_last_accept) begin
          w_next_state = ST_COMMIT;
        end
      end
      default: begin
        w_next_state = ST_SCAN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // Reset gates the read strobe directly so that no FIFO word is popped
  // while reset is asserted, even before the state register has settled.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_en  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_SCAN: begin
        w_rd_en = !in_empty && !reset;
      end
      default: begin
        w_commit = 1'b1;
      end
    endcase
  end

  assign in_rd_en      = w_rd_en;
  assign w_hit         = w_rd_en && (in_dout != 24'h000000);
  assign w_col_last    = (r_col == C_LAST_COL);
  assign w_row_last    = (r_row == C_LAST_ROW);
  assign w_last_accept = w_rd_en && w_col_last && w_row_last;

  // --------------------------------------------------------------------------
  // Raster position of the pixel currently at the FIFO head
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col <= 10'd0;
      r_row <= 10'd0;
    end else if (w_commit) begin
      r_col <= 10'd0;
      r_row <= 10'd0;
    end else if (w_rd_en) begin
      if (w_col_last) begin
        r_col <= 10'd0;
        r_row <= w_row_last ? 10'd0 : r_row + 10'd1;
      end else begin
        r_col <= r_col + 10'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-frame hit trackers. The final pixel of the frame is absorbed on the
  // SCAN->COMMIT edge, so the COMMIT cycle sees the complete frame.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_min_x     <= C_MIN_INIT;
      r_max_x     <= C_MAX_INIT;
      r_min_y     <= C_MIN_INIT;
      r_max_y     <= C_MAX_INIT;
      r_hit_count <= 19'd0;
    end else if (w_commit) begin
      r_min_x     <= C_MIN_INIT;
      r_max_x     <= C_MAX_INIT;
      r_min_y     <= C_MIN_INIT;
      r_max_y     <= C_MAX_INIT;
      r_hit_count <= 19'd0;
    end else if (w_hit) begin
      if (r_col < r_min_x) r_min_x <= r_col;
      if (r_col > r_max_x) r_max_x <= r_col;
      if (r_row < r_min_y) r_min_y <= r_row;
      if (r_row > r_max_y) r_max_y <= r_row;
      if (r_hit_count != C_HIT_SAT) begin
        r_hit_count <= r_hit_count + 19'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Committed box. A full-frame box (max-min+1) reaches 640/480, which still
  // fits in 10 bits.
  // --------------------------------------------------------------------------
  assign w_box_ok = (r_hit_count >= C_MIN_HITS);
  assign w_box_w  = r_max_x - r_min_x + 10'd1;
  assign w_box_h  = r_max_y - r_min_y + 10'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x          <= 10'd0;
      r_y          <= 10'd0;
      r_width      <= 10'd0;
      r_height     <= 10'd0;
      r_box_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_commit;
      if (w_commit) begin
        r_box_valid <= w_box_ok;
        if (w_box_ok) begin
          r_x      <= r_min_x;
          r_y      <= r_min_y;
          r_width  <= w_box_w;
          r_height <= w_box_h;
        end
      end
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign width      = r_width;
  assign height     = r_height;
  assign box_valid  = r_box_valid;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_bbox_extract.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bbox_extract
//  Purpose  : Self-checking bench for bbox_extract. Two instances share one
//             pixel stream: instance 0 uses MIN_HITS=16 and instance 1 uses
//             MIN_HITS=1. A frame-level reference model stores the hit map of
//             each frame and derives the expected box from it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bbox_extract;

  localparam int W    = 101;
  localparam int H    = 51;
  localparam int TH_A = 16;
  localparam int TH_B = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_empty;
  logic [23:0] in_dout;

  logic        rd_en [2];
  logic [9:0]  dx    [2];
  logic [9:0]  dy    [2];
  logic [9:0]  dw    [2];
  logic [9:0]  dh    [2];
  logic        dv    [2];
  logic        dfd   [2];

  int tests = 0;
  int fails = 0;
  int fd_seen [2] = '{0, 0};

  always #5 clock = ~clock;

  bbox_extract #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_HITS(TH_A)) u_dut_a (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(rd_en[0]),
    .in_dout(in_dout), .x(dx[0]), .y(dy[0]), .width(dw[0]), .height(dh[0]),
    .box_valid(dv[0]), .frame_done(dfd[0])
  );

  bbox_extract #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_HITS(TH_B)) u_dut_b (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(rd_en[1]),
    .in_dout(in_dout), .x(dx[1]), .y(dy[1]), .width(dw[1]), .height(dh[1]),
    .box_valid(dv[1]), .frame_done(dfd[1])
  );

  task automatic chk(input int k, input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL dut%0d %s: got %0d expected %0d (t=%0t)", k, nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: collects the frame as a hit map; at the commit cycle the
  // box is derived from the whole map.
  // --------------------------------------------------------------------------
  bit hitmap [H][W];
  int m_col = 0;
  int m_row = 0;
  bit m_commit = 1'b0;
  bit m_fd = 1'b0;
  int ex [2] = '{0, 0};
  int ey [2] = '{0, 0};
  int ew [2] = '{0, 0};
  int eh [2] = '{0, 0};
  int ev [2] = '{0, 0};
  int mc_cnt, mc_minx, mc_maxx, mc_miny, mc_maxy;

  function automatic int thresh(input int k);
    return (k == 0) ? TH_A : TH_B;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) hitmap[r][c] = 1'b0;
      m_col = 0; m_row = 0; m_commit = 1'b0; m_fd = 1'b0;
      for (int k = 0; k < 2; k++) begin
        ex[k] = 0; ey[k] = 0; ew[k] = 0; eh[k] = 0; ev[k] = 0;
      end
    end else begin
      m_fd = 1'b0;
      if (m_commit) begin
        mc_cnt = 0; mc_minx = W; mc_maxx = -1; mc_miny = H; mc_maxy = -1;
        for (int r = 0; r < H; r++) begin
          for (int c = 0; c < W; c++) begin
            if (hitmap[r][c]) begin
              mc_cnt++;
              if (c < mc_minx) mc_minx = c;
              if (c > mc_maxx) mc_maxx = c;
              if (r < mc_miny) mc_miny = r;
              if (r > mc_maxy) mc_maxy = r;
            end
            hitmap[r][c] = 1'b0;
          end
        end
        for (int k = 0; k < 2; k++) begin
          if (mc_cnt >= thresh(k)) begin
            ex[k] = mc_minx; ey[k] = mc_miny;
            ew[k] = mc_maxx - mc_minx + 1; eh[k] = mc_maxy - mc_miny + 1;
            ev[k] = 1;
          end else begin
            ev[k] = 0;
          end
        end
        m_commit = 1'b0; m_col = 0; m_row = 0; m_fd = 1'b1;
      end else if (!in_empty) begin
        hitmap[m_row][m_col] = (in_dout != 24'h0);
        if (m_col == W - 1 && m_row == H - 1) m_commit = 1'b1;
        m_col++;
        if (m_col == W) begin
          m_col = 0;
          m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-cycle comparison of both instances against the model
  // --------------------------------------------------------------------------
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      chk(k, "in_rd_en", int'(rd_en[k]), int'(!in_empty && !m_commit && !reset));
      chk(k, "frame_done", int'(dfd[k]), int'(m_fd));
      chk(k, "x", int'(dx[k]), ex[k]);
      chk(k, "y", int'(dy[k]), ey[k]);
      chk(k, "width", int'(dw[k]), ew[k]);
      chk(k, "height", int'(dh[k]), eh[k]);
      chk(k, "box_valid", int'(dv[k]), ev[k]);
      if (dfd[k] === 1'b1) fd_seen[k]++;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  function automatic logic [23:0] nz_rand();
    logic [23:0] v;
    v = 24'($urandom);
    if (v == 24'h0) v = 24'h000001;
    return v;
  endfunction

  // kind: 0 single (100,50) / 1 block 10..19 x 20..29 / 2 zero /
  //       3 corners / 4 sparse random / 5 n hits on row 7 from col 3
  function automatic logic [23:0] pix(input int kind, input int c, input int r, input int n);
    case (kind)
      0: return (c == 100 && r == 50) ? nz_rand() : 24'h0;
      1: return (c >= 10 && c <= 19 && r >= 20 && r <= 29) ? nz_rand() : 24'h0;
      3: return ((c == 0 && r == 0) || (c == W - 1 && r == H - 1)) ? nz_rand() : 24'h0;
      4: return ($urandom_range(0, 99) < 2) ? nz_rand() : 24'h0;
      5: return (r == 7 && c >= 3 && c < 3 + n) ? nz_rand() : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  // Presents one pixel until it is consumed. Random stalls show junk data,
  // and the word is also offered during the commit cycle, where it must not
  // be taken.
  task automatic drive_pixel(input logic [23:0] v, input int stall_pct);
    bit done = 1'b0;
    while (!done) begin
      @(posedge clock); #1;
      if (m_commit) begin
        in_empty = 1'b0; in_dout = v;
      end else if (int'($urandom_range(0, 99)) < stall_pct) begin
        in_empty = 1'b1; in_dout = 24'($urandom);
      end else begin
        in_empty = 1'b0; in_dout = v;
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      in_empty = 1'b1; in_dout = 24'($urandom);
    end
  endtask

  task automatic feed(input int kind, input int stall_pct, input int n, input int limit);
    int cnt = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (cnt < limit) drive_pixel(pix(kind, c, r, n), stall_pct);
        cnt++;
      end
    end
  endtask

  task automatic frame_check(input int kind, input int stall_pct, input int n);
    int b0, b1;
    b0 = fd_seen[0]; b1 = fd_seen[1];
    feed(kind, stall_pct, n, W * H);
    idle(4);
    chk(0, "frame_done count", fd_seen[0] - b0, 1);
    chk(1, "frame_done count", fd_seen[1] - b1, 1);
  endtask

  task automatic box_check(input int k, input int ax, input int ay, input int aw,
                           input int ah, input int av);
    chk(k, "lit x", int'(dx[k]), ax);
    chk(k, "lit y", int'(dy[k]), ay);
    chk(k, "lit width", int'(dw[k]), aw);
    chk(k, "lit height", int'(dh[k]), ah);
    chk(k, "lit box_valid", int'(dv[k]), av);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1;
    reset = 1'b1; in_empty = 1'b1; in_dout = 24'h0;
    repeat (2) @(posedge clock);
    #1 in_empty = 1'b0; in_dout = 24'h123456;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk(k, "reset in_rd_en", int'(rd_en[k]), 0);
      chk(k, "reset frame_done", int'(dfd[k]), 0);
      box_check(k, 0, 0, 0, 0, 0);
    end
    @(posedge clock); #1 reset = 1'b0; in_empty = 1'b1;

    // Single hit: only the MIN_HITS=1 instance reports a box.
    frame_check(0, 0, 0);
    box_check(1, 100, 50, 1, 1, 1);
    box_check(0, 0, 0, 0, 0, 0);

    // 10x10 block.
    frame_check(1, 0, 0);
    box_check(0, 10, 20, 10, 10, 1);
    box_check(1, 10, 20, 10, 10, 1);

    // Empty frame holds the geometry and clears box_valid.
    frame_check(2, 0, 0);
    box_check(0, 10, 20, 10, 10, 0);
    box_check(1, 10, 20, 10, 10, 0);

    // Opposite corners span the full image.
    frame_check(3, 0, 0);
    box_check(1, 0, 0, W, H, 1);
    box_check(0, 10, 20, 10, 10, 0);

    // Threshold boundary for MIN_HITS=16.
    frame_check(5, 0, 15);
    box_check(0, 10, 20, 10, 10, 0);
    box_check(1, 3, 7, 15, 1, 1);
    frame_check(5, 0, 16);
    box_check(0, 3, 7, 16, 1, 1);

    // Block frame again under heavy stalls.
    frame_check(1, 50, 0);
    box_check(0, 10, 20, 10, 10, 1);
    box_check(1, 10, 20, 10, 10, 1);

    // Reset part-way through a frame, then a clean block frame.
    feed(1, 0, 0, 35 * W + 30);
    @(posedge clock); #1 reset = 1'b1; in_empty = 1'b0; in_dout = 24'hFFFFFF;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0; in_empty = 1'b1;
    box_check(0, 0, 0, 0, 0, 0);
    b0 = fd_seen[0]; b1 = fd_seen[1];
    feed(1, 0, 0, W * H);
    idle(6);
    chk(0, "post-reset frame_done count", fd_seen[0] - b0, 1);
    chk(1, "post-reset frame_done count", fd_seen[1] - b1, 1);
    box_check(0, 10, 20, 10, 10, 1);
    box_check(1, 10, 20, 10, 10, 1);

    // Sparse random content with random stalls; the model checks it.
    frame_check(4, 25, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
